// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: arms the UART receiver, screens and buffers received bytes in a
// show-ahead FIFO, recovers stalled frames by timeout. Define UART_RX_CTRL_STATS_EN for error/drop counters.
module uart_rx_ctrl #(
    parameter int unsigned      ADDR_W  = 2,
    parameter int unsigned      CNT_W   = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = 16'd2000,
    parameter int unsigned      THRESH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clr_status,
    input  logic              rx_busy,
    input  logic              rx_done,
    input  logic              rx_error,
    input  logic [7:0]        rx_byte,
    output logic              rx_en,
    output logic              rx_rst,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic [ADDR_W:0]   fifo_count,
    output logic              empty,
    output logic              full,
    output logic              overrun,
    output logic              frame_err,
    output logic              timeout_err,
    output logic              irq
`ifdef UART_RX_CTRL_STATS_EN
    ,
    output logic [7:0]        err_cnt,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int unsigned        DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]    DEPTH_L  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]    THRESH_L = (ADDR_W+1)'(THRESH);
    localparam logic [CNT_W-1:0]   TO_LAST  = TIMEOUT - 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_BYTE,
        CAPTURE,
        CHECK,
        RECOVER
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               rx_done_q;
    logic               done_rise;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         hold;
    logic               err_q;
    logic [7:0]         mem [DEPTH];
    logic [ADDR_W:0]    wr_ptr;
    logic [ADDR_W:0]    rd_ptr;
    logic               push;
    logic               pop;
    logic               drop_ev;
    logic               ferr_ev;
    logic               to_ev;

    assign done_rise  = rx_done & ~rx_done_q;
    assign fifo_count = wr_ptr - rd_ptr;
    assign empty      = (fifo_count == '0);
    assign full       = (fifo_count == DEPTH_L);
    assign rd_data    = mem[rd_ptr[ADDR_W-1:0]];

    // A full FIFO still accepts the byte when a pop retires the head on the same edge.
    assign push    = (state == CHECK) & ~err_q & (~full | rd_en);
    assign drop_ev = (state == CHECK) & ~err_q & full & ~rd_en;
    assign ferr_ev = (state == CHECK) & err_q;
    assign to_ev   = (state == RECOVER);
    assign pop     = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_en      = 1'b0;
        rx_rst     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = ARM;
            end
            ARM: begin
                rx_en = 1'b1;
                if (rx_busy)      state_next = WAIT_BYTE;
                else if (!enable) state_next = IDLE;
            end
            WAIT_BYTE: begin
                if (done_rise)           state_next = CAPTURE;
                else if (cnt == TO_LAST) state_next = RECOVER;
            end
            CAPTURE: begin
                state_next = CHECK;
            end
            CHECK: begin
                state_next = enable ? ARM : IDLE;
            end
            RECOVER: begin
                rx_rst     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_done_q <= 1'b0;
            cnt       <= '0;
            hold      <= '0;
            err_q     <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            if (state == WAIT_BYTE && state_next == WAIT_BYTE) cnt <= cnt + 1'b1;
            else                                              cnt <= '0;
            if (state == WAIT_BYTE && done_rise) hold <= rx_byte;
            // rx_error is only valid the cycle after the rise, so it is held for CHECK.
            if (state == CAPTURE) err_q <= rx_error;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[ADDR_W-1:0]] <= hold;
                wr_ptr                  <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (drop_ev)         overrun <= 1'b1;
            else if (clr_status) overrun <= 1'b0;
            if (ferr_ev)         frame_err <= 1'b1;
            else if (clr_status) frame_err <= 1'b0;
            if (to_ev)           timeout_err <= 1'b1;
            else if (clr_status) timeout_err <= 1'b0;
            irq <= (fifo_count >= THRESH_L) | overrun | frame_err | timeout_err;
        end
    end

`ifdef UART_RX_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || clr_status) begin
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (ferr_ev && err_cnt != 8'hFF)  err_cnt  <= err_cnt + 1'b1;
            if (drop_ev && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule
